// File: rtl/cic_pkg.sv
// Shared defaults and width helpers for the CIC decimator and its comb stages.
package cic_pkg;

    localparam int IN_W_DEF   = 16;
    localparam int OUT_W_DEF  = 16;
    localparam int STAGES_DEF = 3;
    localparam int DECIM_DEF  = 8;

    // Ceiling log2; exact for the power-of-two ratios the decimator accepts.
    function automatic int log2_int(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Internal width: enough headroom for the DECIM^STAGES gain.
    function automatic int cic_width(input int in_w, input int stages, input int decim);
        return in_w + stages * log2_int(decim);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One pipelined comb section (differential delay 1): y = x - x_prev,
// advancing only when the decimate strobe travels through it.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int W = cic_width(IN_W_DEF, STAGES_DEF, DECIM_DEF)
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [W-1:0] x_i,
    input  logic         stb_i,
    output logic [W-1:0] y_o,
    output logic         stb_o
);

    logic [W-1:0] y_q, y_d;
    logic [W-1:0] dly_q;
    logic         stb_q;

    assign y_d = x_i - dly_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            y_q   <= '0;
            dly_q <= '0;
            stb_q <= 1'b0;
        end else begin
            stb_q <= stb_i;
            if (stb_i) begin
                y_q   <= y_d;
                dly_q <= x_i;
            end
        end
    end

    assign y_o   = y_q;
    assign stb_o = stb_q;

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator: inline wrapping integrators at the input rate, a pipelined
// comb chain at the output rate, and a truncating output register.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int DECIM  = DECIM_DEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic signed [IN_W-1:0]  in,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid
);

    localparam int W    = cic_width(IN_W, STAGES, DECIM);
    localparam int PH_W = log2_int(DECIM);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [W-1:0]               in_ext;
    logic [STAGES-1:0][W-1:0]   integ_q, integ_d;
    logic [PH_W-1:0]            ph_q, ph_d;
    logic                       dec_stb_q, dec_stb_d;
    logic [W-1:0]               cap_q;
    logic                       cap_stb_q;
    logic [STAGES:0][W-1:0]     comb_x;
    logic [STAGES:0]            comb_stb;
    logic [OUT_W-1:0]           out_q;
    logic                       out_valid_q;
    logic                       unused_lsb;

    assign in_ext = {{(W - IN_W){in[IN_W-1]}}, in};

    // Each integrator adds the previous stage's old value; wrap is harmless.
    always_comb begin
        integ_d = integ_q;
        if (in_valid) begin
            integ_d[0] = integ_q[0] + in_ext;
            for (int k = 1; k < STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    always_comb begin
        ph_d      = ph_q;
        dec_stb_d = 1'b0;
        if (in_valid) begin
            ph_d      = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
            dec_stb_d = (ph_q == PH_LAST);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            integ_q   <= '0;
            ph_q      <= '0;
            dec_stb_q <= 1'b0;
            cap_q     <= '0;
            cap_stb_q <= 1'b0;
        end else begin
            integ_q   <= integ_d;
            ph_q      <= ph_d;
            dec_stb_q <= dec_stb_d;
            cap_stb_q <= dec_stb_q;
            if (dec_stb_q) cap_q <= integ_q[STAGES-1];
        end
    end

    assign comb_x[0]   = cap_q;
    assign comb_stb[0] = cap_stb_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        cic_comb_stage #(.W(W)) u_comb (
            .aclk    (aclk),
            .aresetn (aresetn),
            .x_i     (comb_x[g]),
            .stb_i   (comb_stb[g]),
            .y_o     (comb_x[g+1]),
            .stb_o   (comb_stb[g+1])
        );
    end

    // Keeping the top OUT_W bits divides out the DECIM^STAGES gain (floor).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= comb_stb[STAGES];
            if (comb_stb[STAGES]) out_q <= comb_x[STAGES][W-1 -: OUT_W];
        end
    end

    assign unused_lsb = ^comb_x[STAGES];
    assign out        = out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator with default parameters (W = 25).
module tb_cic_decimator;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int STAGES = 3;
    localparam int DECIM  = 8;
    localparam int LAT    = STAGES + 2;

    logic                    aclk = 1'b0;
    logic                    aresetn = 1'b0;
    logic signed [IN_W-1:0]  in_s = '0;
    logic                    in_valid = 1'b0;
    logic signed [OUT_W-1:0] out_s;
    logic                    out_valid;

    cic_decimator #(
        .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .DECIM(DECIM)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in        (in_s),
        .in_valid  (in_valid),
        .out       (out_s),
        .out_valid (out_valid)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // mono: 0 none, 1 non-decreasing, -1 non-increasing, 2 sine peak tracking
    typedef struct {
        int    lo;
        int    hi;
        int    mono;
        int    cyc;
        string name;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    int    cur_lo = 0, cur_hi = 0, cur_mono = 0;
    string cur_name = "none";
    int    phase = 0;

    int    sine_n = 0;
    int    sine_max = -100000;
    int    sine_min = 100000;

    function automatic void chk(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endfunction

    // One input-clock edge; every DECIM-th accepted sample books an output.
    task automatic drive(input int v, input bit vld);
        in_s     = 16'(v);
        in_valid = vld;
        @(posedge aclk);
        #1;
        if (vld) begin
            if (phase == DECIM - 1) begin
                sb.push_back('{cur_lo, cur_hi, cur_mono, cyc + LAT, cur_name});
                phase = 0;
            end else begin
                phase++;
            end
        end
    endtask

    task automatic frame(input int v, input int gap, input int lo, input int hi,
                         input int mono, input string name);
        cur_lo = lo; cur_hi = hi; cur_mono = mono; cur_name = name;
        for (int i = 0; i < DECIM; i++) begin
            for (int j = 0; j < gap; j++) drive(v, 1'b0);
            drive(v, 1'b1);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe, checks hold and reset in between.
    initial begin
        exp_t e;
        int   prev_out;
        bit   prev_valid;
        prev_out   = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                chk("reset_out", out_s, 0, 0);
                chk("reset_valid", out_valid, 0, 0);
                prev_out   = 0;
                prev_valid = 1'b0;
            end else if (out_valid) begin
                chk("single_strobe", prev_valid, 0, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_cycle"}, cyc, e.cyc, e.cyc);
                    chk(e.name, out_s, e.lo, e.hi);
                    if (e.mono == 1) chk({e.name, "_mono"}, out_s, prev_out, 32767);
                    else if (e.mono == -1) chk({e.name, "_mono"}, out_s, -32768, prev_out);
                    else if (e.mono == 2) begin
                        sine_n++;
                        if (sine_n > 20) begin
                            if (out_s > sine_max) sine_max = out_s;
                            if (out_s < sine_min) sine_min = out_s;
                        end
                    end
                end
                prev_out   = out_s;
                prev_valid = 1'b1;
            end else begin
                chk("hold", out_s, prev_out, prev_out);
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        int pacc;
        int v;
        repeat (3) @(posedge aclk);
        #1;
        chk("init_out", out_s, 0, 0);
        chk("init_valid", out_valid, 0, 0);
        aresetn = 1'b1;

        // Continuous DC 1000: start-up transient 109, 765, then unity gain.
        frame(1000, 0, 109, 109, 0, "dc_start1");
        frame(1000, 0, 765, 765, 0, "dc_start2");
        for (int f = 0; f < 4; f++) frame(1000, 0, 1000, 1000, 0, "dc_cont");

        // in_valid every other cycle: same value, strobe every 16 cycles.
        for (int f = 0; f < 6; f++) frame(1000, 1, 1000, 1000, 0, "dc_gap");

        // Full-scale steps, long enough for the integrators to wrap many times.
        for (int f = 0; f < 2500; f++) begin
            if (f < 4) frame(32767, 0, 1000, 32767, 1, "step_up");
            else       frame(32767, 0, 32767, 32767, 0, "pos_full");
        end
        for (int f = 0; f < 44; f++) begin
            if (f < 4) frame(-32768, 0, -32768, 32767, -1, "step_dn");
            else       frame(-32768, 0, -32768, -32768, 0, "neg_full");
        end

        // Reset after the 5th sample of a frame, just as the last strobe fires.
        cur_lo = -32768; cur_hi = -32768; cur_mono = 0; cur_name = "neg_full";
        for (int i = 0; i < 5; i++) drive(-32768, 1'b1);
        chk("pre_reset_valid", out_valid, 1, 1);
        chk("pre_reset_out", out_s, -32768, -32768);
        aresetn  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_reset_out", out_s, 0, 0);
        chk("async_reset_valid", out_valid, 0, 0);
        sb.delete();
        phase = 0;
        repeat (3) drive(0, 1'b0);
        aresetn = 1'b1;
        frame(1000, 0, 109, 109, 0, "post_rst1");
        frame(1000, 0, 765, 765, 0, "post_rst2");
        frame(1000, 0, 1000, 1000, 0, "post_rst3");

        // Sine from a 24-bit phase accumulator, increment 8389, amplitude 30000.
        cur_lo = -32768; cur_hi = 32767; cur_mono = 2; cur_name = "sine";
        pacc = 0;
        for (int n = 0; n < 4800; n++) begin
            v = $rtoi($floor(30000.0 * $sin(2.0 * 3.14159265358979 * real'(pacc) / 16777216.0) + 0.5));
            drive(v, 1'b1);
            pacc = (pacc + 8389) & 32'h00FF_FFFF;
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge aclk);
        @(negedge aclk);
        chk("drain", sb.size(), 0, 0);
        chk("sine_max", sine_max, 29700, 30300);
        chk("sine_min", sine_min, -30300, -29700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
